// File: rtl/mix_float_pkg.sv
// Shared constants and encodings for the MIX floating-point execution units.
// Word layout is {sign, excess-32 exponent, four 6-bit fraction bytes}.
package mix_float_pkg;
   localparam logic [6:0] EXP_BIAS  = 7'o040;
   localparam int         SIGN_BIT  = 30;
   localparam int         EXP_MSB   = 29;
   localparam int         EXP_LSB   = 24;
   localparam int         FRAC_W    = 24;
   localparam int         BYTE_W    = 6;
   localparam int         DIV_STEPS = 36;

   // Fraction value of exactly one top byte unit: byte 3 = 1, rest 0.
   localparam logic [FRAC_W-1:0] FRAC_ONE = FRAC_W'(1) << (FRAC_W - BYTE_W);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DIV,
      ST_DONE
   } state_t;
endpackage

// File: rtl/fround.sv
// Ties-to-even rounding, renormalise on carry-out and pack into a MIX float word.
// Shared by the divider and the multiplier's pack stage.
module fround
   import mix_float_pkg::*;
(
   input  logic              sign,
   input  logic [6:0]        exp7,
   input  logic [FRAC_W-1:0] frac,
   input  logic              rnd,
   input  logic              stk,
   output logic [30:0]       out,
   output logic              ovf
);
   logic              inc;
   logic [FRAC_W:0]   sum;
   logic [6:0]        exp_r;
   logic [FRAC_W-1:0] frac_r;

   always_comb begin
      inc    = rnd & (stk | frac[0]);
      sum    = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
      frac_r = sum[FRAC_W-1:0];
      exp_r  = exp7;
      // All-ones fraction rounded up: shift in a whole byte and bump the exponent.
      if (sum[FRAC_W]) begin
         frac_r = FRAC_ONE;
         exp_r  = exp7 + 7'd1;
      end
      // Seven-bit wrap makes bit 6 flag both overflow and underflow.
      ovf = exp_r[6];
      out = {sign, exp_r[5:0], frac_r};
   end
endmodule

// File: rtl/fdiv.sv
// MIX FDIV unit: fixed 38-cycle restoring divide of 24-bit fractions,
// followed by normalise, round and pack through fround.
module fdiv
   import mix_float_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [30:0] in1,
   input  logic [30:0] in2,
   output logic [30:0] out,
   output logic        stop,
   output logic        overflow,
   output logic        busy
);
   state_t      state_q, state_d;
   logic [30:0] a_q, a_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [30:0] rem_q, rem_d;
   logic [28:0] dsr_q, dsr_d;
   logic [34:0] quo_q, quo_d;
   logic        sign_q, sign_d;
   logic [6:0]  exp_q, exp_d;
   logic        dz_q, dz_d;
   logic        nz_q, nz_d;
   logic [30:0] out_q, out_d;
   logic        ovf_q, ovf_d;
   logic        stop_q, stop_d;
   logic        busy_q, busy_d;

   logic              q_bit;
   logic [30:0]       diff;
   logic [30:0]       rem_step;
   logic [35:0]       quo_step;
   logic              hi;
   logic [FRAC_W-1:0] frac_n;
   logic              rnd_n;
   logic              stk_n;
   logic [6:0]        exp_n;
   logic [30:0]       pack_out;
   logic              pack_ovf;
   logic [30:0]       res_out;
   logic              res_ovf;

   // One restoring step; quo_step is the full 36-bit quotient on the last step.
   always_comb begin
      q_bit    = rem_q >= {2'b00, dsr_q};
      diff     = rem_q - (q_bit ? {2'b00, dsr_q} : 31'd0);
      rem_step = diff << 1;
      quo_step = {quo_q, q_bit};
      hi       = |quo_step[35:30];
      frac_n   = hi ? quo_step[35:12] : quo_step[29:6];
      rnd_n    = hi ? quo_step[11] : quo_step[5];
      stk_n    = (hi ? |quo_step[10:0] : |quo_step[4:0]) | (|rem_step);
      exp_n    = exp_q + {6'd0, hi};
   end

   fround u_fround (
      .sign (sign_q),
      .exp7 (exp_n),
      .frac (frac_n),
      .rnd  (rnd_n),
      .stk  (stk_n),
      .out  (pack_out),
      .ovf  (pack_ovf)
   );

   always_comb begin
      res_out = pack_out;
      res_ovf = pack_ovf;
      if (dz_q) begin
         res_out = 31'd0;
         res_ovf = 1'b1;
      end else if (nz_q) begin
         res_out = {sign_q, 30'd0};
         res_ovf = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dsr_d   = dsr_q;
      quo_d   = quo_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      dz_d    = dz_q;
      nz_d    = nz_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      stop_d  = 1'b0;
      // A start in any state restarts, silently dropping an operation in flight.
      if (start) begin
         state_d = ST_LOAD;
         a_d     = in1;
      end else begin
         case (state_q)
            ST_LOAD: begin
               sign_d  = a_q[SIGN_BIT] ^ in2[SIGN_BIT];
               exp_d   = {1'b0, a_q[EXP_MSB:EXP_LSB]} - {1'b0, in2[EXP_MSB:EXP_LSB]} + EXP_BIAS;
               dsr_d   = {in2[FRAC_W-1:0], 5'd0};
               rem_d   = {7'd0, a_q[FRAC_W-1:0]};
               quo_d   = 35'd0;
               cnt_d   = 6'd0;
               dz_d    = in2[FRAC_W-1:0] == '0;
               nz_d    = a_q[FRAC_W-1:0] == '0;
               state_d = ST_DIV;
            end
            ST_DIV: begin
               rem_d = rem_step;
               quo_d = quo_step[34:0];
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(DIV_STEPS - 1)) begin
                  state_d = ST_DONE;
                  out_d   = res_out;
                  ovf_d   = res_ovf;
                  stop_d  = 1'b1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = state_d != ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         dsr_q   <= '0;
         quo_q   <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         dz_q    <= 1'b0;
         nz_q    <= 1'b0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         stop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dsr_q   <= dsr_d;
         quo_q   <= quo_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         dz_q    <= dz_d;
         nz_q    <= nz_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         stop_q  <= stop_d;
         busy_q  <= busy_d;
      end
   end

   assign out      = out_q;
   assign overflow = ovf_q;
   assign stop     = stop_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_fdiv.sv
// Directed bench for fdiv (latency, quotients, exceptions, abort/reset)
// plus direct vectors on the shared fround pack stage.
module tb_fdiv;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [30:0] in1;
   logic [30:0] in2;
   logic [30:0] out;
   logic        stop;
   logic        overflow;
   logic        busy;

   logic        fr_sign;
   logic [6:0]  fr_exp;
   logic [23:0] fr_frac;
   logic        fr_rnd;
   logic        fr_stk;
   logic [30:0] fr_out;
   logic        fr_ovf;

   int errors = 0;
   int checks = 0;

   localparam logic [30:0] ONE   = {1'b0, 6'o41, 24'o01000000};
   localparam logic [30:0] TWO   = {1'b0, 6'o41, 24'o02000000};
   localparam logic [30:0] THREE = {1'b0, 6'o41, 24'o03000000};
   localparam logic [30:0] MTHR  = {1'b1, 6'o41, 24'o03000000};
   localparam logic [30:0] Q_2_3 = {1'b0, 6'o40, 24'o52525253};

   always #5 clk = ~clk;

   fdiv dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in1      (in1),
      .in2      (in2),
      .out      (out),
      .stop     (stop),
      .overflow (overflow),
      .busy     (busy)
   );

   fround u_fround (
      .sign (fr_sign),
      .exp7 (fr_exp),
      .frac (fr_frac),
      .rnd  (fr_rnd),
      .stk  (fr_stk),
      .out  (fr_out),
      .ovf  (fr_ovf)
   );

   task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic run_op(input string tag, input logic [30:0] a, input logic [30:0] b,
                         input logic [30:0] want_out, input logic want_ovf);
      int n;
      @(negedge clk);
      start = 1'b1;
      in1   = a;
      in2   = 31'd0;
      @(negedge clk);
      start = 1'b0;
      in1   = 31'h7fffffff;
      in2   = b;
      n     = 1;
      chk({tag, ".busy_t1"}, 36'(busy), 36'd1);
      @(negedge clk);
      in2 = ~b;
      n   = 2;
      while (!stop && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, 36'(n), 36'd38);
      chk({tag, ".out"}, 36'(out), 36'(want_out));
      chk({tag, ".ovf"}, 36'(overflow), 36'(want_ovf));
      $display("op %s: in1=%o in2=%o out=%o ovf=%b stop_at=T%0d", tag, a, b, out, overflow, n);
      @(negedge clk);
      chk({tag, ".stop_pulse"}, 36'(stop), 36'd0);
      chk({tag, ".busy_end"}, 36'(busy), 36'd0);
      chk({tag, ".hold"}, 36'(out), 36'(want_out));
   endtask

   task automatic round_vec(input string tag, input logic s, input logic [6:0] e,
                            input logic [23:0] f, input logic r, input logic k,
                            input logic [30:0] want_out, input logic want_ovf);
      fr_sign = s;
      fr_exp  = e;
      fr_frac = f;
      fr_rnd  = r;
      fr_stk  = k;
      #1;
      chk({tag, ".out"}, 36'(fr_out), 36'(want_out));
      chk({tag, ".ovf"}, 36'(fr_ovf), 36'(want_ovf));
      $display("round %s: exp=%o frac=%o rnd=%b stk=%b -> out=%o ovf=%b", tag, e, f, r, k, fr_out, fr_ovf);
   endtask

   initial begin
      int stops;
      int stop_at;
      logic [30:0] abort_out;
      reset = 1'b1;
      start = 1'b0;
      in1   = 31'd0;
      in2   = 31'd0;
      repeat (3) @(negedge clk);
      chk("reset.out", 36'(out), 36'd0);
      chk("reset.stop", 36'(stop), 36'd0);
      chk("reset.ovf", 36'(overflow), 36'd0);
      chk("reset.busy", 36'(busy), 36'd0);
      reset = 1'b0;

      run_op("1/1", ONE, ONE, ONE, 1'b0);
      run_op("1/-3", ONE, MTHR, {1'b1, 6'o40, 24'o25252525}, 1'b0);
      run_op("2/3", TWO, THREE, Q_2_3, 1'b0);
      run_op("div0", ONE, {1'b0, 6'o41, 24'o0}, 31'd0, 1'b1);
      run_op("zero/1", {1'b1, 6'o41, 24'o0}, ONE, {1'b1, 30'd0}, 1'b0);
      run_op("exp_ovf", {1'b0, 6'o77, 24'o01000000}, {1'b0, 6'o01, 24'o01000000},
             {1'b0, 6'o37, 24'o01000000}, 1'b1);
      run_op("exp_unf", {1'b0, 6'o00, 24'o01000000}, {1'b0, 6'o77, 24'o01000000},
             {1'b0, 6'o42, 24'o01000000}, 1'b1);

      // Reset at T10 of an operation: no stop, outputs cleared.
      @(negedge clk);
      start = 1'b1;
      in1   = ONE;
      @(negedge clk);
      start = 1'b0;
      in2   = ONE;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset.busy", 36'(busy), 36'd0);
      chk("midreset.out", 36'(out), 36'd0);
      chk("midreset.ovf", 36'(overflow), 36'd0);
      stops = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stop) stops++;
      end
      chk("midreset.nostop", 36'(stops), 36'd0);
      $display("op midreset: busy=%b out=%o stops=%0d", busy, out, stops);

      // Reset and start in the same cycle: reset wins.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      in1   = ONE;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      in2   = ONE;
      chk("rst_start.busy", 36'(busy), 36'd0);
      stops = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (stop) stops++;
      end
      chk("rst_start.nostop", 36'(stops), 36'd0);
      $display("op rst_start: busy=%b stops=%0d", busy, stops);

      // Restart at T20 with new operands: one stop at T58 carrying the second result.
      stops     = 0;
      stop_at   = 0;
      abort_out = 31'd0;
      for (int n = 0; n < 70; n++) begin
         @(negedge clk);
         if (stop) begin
            stops++;
            stop_at   = n;
            abort_out = out;
         end
         start = (n == 0) || (n == 20);
         if (n == 0) in1 = ONE;
         if (n == 1) in2 = ONE;
         if (n == 20) in1 = TWO;
         if (n == 21) in2 = THREE;
         if (n == 22) in2 = 31'd0;
      end
      chk("abort.stops", 36'(stops), 36'd1);
      chk("abort.stop_at", 36'(stop_at), 36'd58);
      chk("abort.out", 36'(abort_out), 36'(Q_2_3));
      $display("op abort: stops=%0d stop_at=T%0d out=%o", stops, stop_at, abort_out);

      round_vec("carry", 1'b0, 7'o40, 24'o77777777, 1'b1, 1'b0, {1'b0, 6'o41, 24'o01000000}, 1'b0);
      round_vec("tie_even", 1'b0, 7'o40, 24'o01000000, 1'b1, 1'b0, {1'b0, 6'o40, 24'o01000000}, 1'b0);
      round_vec("tie_odd", 1'b1, 7'o40, 24'o01000001, 1'b1, 1'b0, {1'b1, 6'o40, 24'o01000002}, 1'b0);
      round_vec("carry_ovf", 1'b0, 7'o77, 24'o77777777, 1'b1, 1'b1, {1'b0, 6'o00, 24'o01000000}, 1'b1);
      round_vec("no_rnd", 1'b0, 7'o40, 24'o01000003, 1'b0, 1'b1, {1'b0, 6'o40, 24'o01000003}, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fdiv.md
# fdiv

Floating-point divide unit for the MIX CPU's FDIV instruction (opcode 4, field 6), companion to the floating multiplier on the same execution bus. It takes the accumulator word as dividend at `start` and the memory operand as divisor one cycle later, runs a one-bit-per-cycle restoring division on the 24-bit fractions, then normalises, rounds and packs a MIX float into `out`. Completion is a one-cycle `stop` pulse with `out`/`overflow` registered and held.

## Interface
Parameters: none. Constants come from the shared package.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; `in1` valid this cycle
- `in1`  in  31  dividend, {sign, exp[5:0], fraction[23:0]}
- `in2`  in  31  divisor, same format; valid the cycle after `start` (T1) only
- `out`  out  31  quotient; registered, held until next `start`
- `stop`  out  1  one-cycle completion pulse
- `overflow`  out  1  exponent out of range or divide by zero; valid with `stop`, held
- `busy`  out  1  high from T1 through `stop`

## Operation
- Format: sign bit 30, exponent excess-32 (7'o040), fraction = four 6-bit bytes. Inputs are normalised (fraction byte 3 nonzero) or zero.
- State machine: IDLE -> LOAD (T1) -> DIV (36 cycles, T2..T37) -> DONE (T38, `stop`=1) -> IDLE.
- LOAD: sign = in1[30]^in2[30]; 7-bit exp = e1 - e2 + 7'o040; D = f2<<5 (29 bits); R = f1 (31-bit reg).
- DIV step k=0..35: q[35-k] = (R >= D); R <= 2·(R - q·D). Result Q = floor(f1·2^30/f2), 36 bits; sticky = (final R != 0).
- Normalise: Q[35:30]!=0 -> frac = Q[35:12], rnd = Q[11], stk = |Q[10:0] | sticky, exp+1; else frac = Q[29:6], rnd = Q[5], stk = |Q[4:0] | sticky.
- Round to nearest, ties-to-even: increment iff rnd & (stk | frac[0]). Carry out to 2^24 -> frac = 24'o01000000, exp+1.
- overflow = exp[6] (7-bit wrap covers both >63 and <0); out = {sign, exp[5:0], frac} regardless.
- Divisor fraction zero: overflow=1, out=31'd0; DIV still runs full length (fixed latency).
- Dividend fraction zero (divisor nonzero): out = {sign, 30'd0}, overflow=0.

## Timing
- Reset: state IDLE, `out`=0, `stop`=0, `overflow`=0, `busy`=0.
- Latency fixed: `start` at T0 -> `stop` at T38. Never data-dependent.
- `start` while busy: aborts current op, restarts at T0; no `stop` for the aborted op.
- `reset` and `start` same cycle: reset wins.
- Reset mid-operation: returns to IDLE next edge, no `stop`, outputs cleared.
- `in2` is sampled only at T1; later changes are ignored.
- `out`/`overflow` update in the DONE cycle only and hold until the next `stop` or reset.

## Structure
- Shared package `mix_float_pkg`: EXP_BIAS=7'o040, field positions (SIGN_BIT=30, EXP_MSB=29, EXP_LSB=24, FRAC_W=24, BYTE_W=6), and the IDLE/LOAD/DIV/DONE state encoding.
- One sub-module: `fround`, the combinational ties-to-even round, renormalise and pack. It takes {sign, exp7, frac24, rnd, stk} and returns {out31, ovf}. It is written for reuse by the multiplier's pack stage.
- The divider datapath (R, D, Q, 6-bit step counter) stays in `fdiv`.

## Test plan
- 1.0/1.0: in1=in2={0,6'o41,24'o01000000} -> `stop` at exactly T38, out={0,6'o41,24'o01000000}, overflow=0.
- 1.0/-3.0: in2={1,6'o41,24'o03000000} -> out={1,6'o40,24'o25252525}, overflow=0. Checks the no-round path and the sign.
- Divide by zero: in2 fraction 0 -> overflow=1, out=0, `stop` at T38.
- Exponent overflow and underflow: e1=6'o77, e2=6'o01, fractions equal -> overflow=1. Separately, e1=0, e2=6'o77 -> overflow=1.
- Rounding carry: pick f1/f2 with Q[29:6]=24'o77777777 and rnd=1 -> frac=24'o01000000, exp incremented by one.
- Control: `reset` at T10 -> no `stop`, busy=0, out=0. A second `start` at T20 -> single `stop` at T58.
